// File: rtl/dcache_responder_pkg.sv
// CACHE: request command and responder FSM state encodings shared by the dcache responder.
package CACHE;
  typedef enum logic [1:0] {CMD_IDLE, CMD_READ, CMD_WRITE, CMD_FLUSH} cache_cmd_t;
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MREQ, S_MWAIT, S_RESP} resp_state_t;
endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: direct-mapped valid/tag/data store with async read, one write and one invalidate port.
module dcache_line_array #(
  parameter int LINES = 64,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 61 - IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [63:0]      rd_data,
  input  logic             wr_en,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [63:0]      wr_data,
  input  logic             inv_en
);
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [63:0]      data [LINES];
  always_ff @(posedge clk or negedge reset)
    if (!reset) valid <= '0;
    else if (wr_en) valid[idx] <= 1'b1;
    else if (inv_en) valid[idx] <= 1'b0;
  always_ff @(posedge clk)
    if (wr_en) begin
      tags[idx] <= wr_tag;
      data[idx] <= wr_data;
    end
  assign rd_valid = valid[idx];
  assign rd_tag   = tags[idx];
  assign rd_data  = data[idx];
endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: write-through, no-write-allocate direct-mapped dcache answering one pulse per command.
module dcache_responder
  import CACHE::*;
#(
  parameter int LINES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  cache_cmd_t  ca_req_cmd,
  input  logic [63:0] ca_req_addr,
  input  logic [63:0] ca_req_data,
  output logic        ca_respcyc,
  output logic [63:0] ca_resp_data,
  output logic        mem_req_valid,
  output logic        mem_req_write,
  output logic [63:0] mem_req_addr,
  output logic [63:0] mem_req_data,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 61 - IDX_W;
  resp_state_t state;
  cache_cmd_t  cmd_q;
  logic [63:3] addr_q;
  logic [63:0] data_q;
  logic        hit_q;
  logic        rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [63:0] rd_data;
  logic        hit;
  logic        wr_en;
  logic        inv_en;
  assign hit    = rd_valid && rd_tag == addr_q[63 -: TAG_W];
  assign inv_en = state == S_LOOKUP && cmd_q == CMD_FLUSH && hit;
  // Fill on read responses; update only lines that hit at lookup (no write-allocate).
  assign wr_en  = state == S_MWAIT && mem_resp_valid && (cmd_q == CMD_READ || hit_q);
  dcache_line_array #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_lines (
    .clk      (clk),
    .reset    (reset),
    .idx      (addr_q[3 +: IDX_W]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_tag   (addr_q[63 -: TAG_W]),
    .wr_data  (cmd_q == CMD_READ ? mem_resp_data : data_q),
    .inv_en   (inv_en)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state         <= S_IDLE;
      cmd_q         <= CMD_IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      hit_q         <= 1'b0;
      ca_respcyc    <= 1'b0;
      ca_resp_data  <= '0;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (ca_req_cmd != CMD_IDLE) begin
            cmd_q  <= ca_req_cmd;
            addr_q <= ca_req_addr[63:3];
            data_q <= ca_req_data;
            state  <= S_LOOKUP;
          end
        S_LOOKUP: begin
          hit_q <= hit;
          if (cmd_q == CMD_FLUSH || (cmd_q == CMD_READ && hit)) begin
            ca_respcyc   <= 1'b1;
            ca_resp_data <= cmd_q == CMD_READ ? rd_data : '0;
            state        <= S_RESP;
          end else begin
            mem_req_valid <= 1'b1;
            mem_req_write <= cmd_q == CMD_WRITE;
            mem_req_addr  <= {addr_q, 3'b000};
            mem_req_data  <= cmd_q == CMD_WRITE ? data_q : '0;
            state         <= S_MREQ;
          end
        end
        S_MREQ:
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_MWAIT;
          end
        S_MWAIT:
          if (mem_resp_valid) begin
            ca_respcyc   <= 1'b1;
            ca_resp_data <= cmd_q == CMD_READ ? mem_resp_data : '0;
            state        <= S_RESP;
          end
        default: begin
          ca_respcyc   <= 1'b0;
          ca_resp_data <= '0;
          state        <= S_IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: randomized scoreboard bench against an address-keyed cache/memory reference model.
module tb_dcache_responder;
  import CACHE::*;
  logic clk = 0, reset = 0;
  cache_cmd_t ca_req_cmd = CMD_IDLE;
  logic [63:0] ca_req_addr = '0, ca_req_data = '0;
  logic ca_respcyc, mem_req_valid, mem_req_write;
  logic [63:0] ca_resp_data, mem_req_addr, mem_req_data;
  logic mem_req_ready = 0, mem_resp_valid = 0;
  logic [63:0] mem_resp_data = '0;

  dcache_responder dut (
    .clk(clk), .reset(reset), .ca_req_cmd(ca_req_cmd), .ca_req_addr(ca_req_addr),
    .ca_req_data(ca_req_data), .ca_respcyc(ca_respcyc), .ca_resp_data(ca_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {logic w; logic [63:0] a; logic [63:0] d;} mop_t;
  typedef struct {logic [63:0] d; bit miss;} rop_t;
  mop_t exp_mem_q[$];
  rop_t exp_resp_q[$];
  int total = 0, bad = 0;
  longint cyc = 0, rv_cyc = -100;
  int force_stall = -1;
  bit hold_resp = 0, accepted = 0;
  logic [63:0] amem[logic [63:0]];
  logic [63:0] refmem[logic [63:0]];
  logic [63:0] cached[logic [63:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] init_val(input logic [63:0] a);
    return (a * 64'h9E3779B97F4A7C15) ^ 64'h0123456789ABCDEF;
  endfunction

  function automatic int idx_of(input logic [63:0] a);
    return int'((a >> 3) & 64'd63);
  endfunction

  // Memory-side agent: checks each request against the expected queue, stalls, then answers.
  initial begin
    mop_t m;
    logic w;
    logic [63:0] a, d;
    int st, k;
    forever begin
      @(negedge clk);
      if (reset && mem_req_valid) begin
        w = mem_req_write; a = mem_req_addr; d = mem_req_data;
        chk("mem_req_expected", 64'(exp_mem_q.size() > 0), 64'd1);
        if (exp_mem_q.size() > 0) begin
          m = exp_mem_q.pop_front();
          chk("mem_write", 64'(w), 64'(m.w));
          chk("mem_addr", a, m.a);
          if (m.w) chk("mem_wdata", d, m.d);
        end
        st = force_stall >= 0 ? force_stall : int'($urandom_range(0, 3));
        repeat (st) begin
          @(negedge clk);
          chk("mem_hold_valid", 64'(mem_req_valid), 64'd1);
          chk("mem_hold_write", 64'(mem_req_write), 64'(w));
          chk("mem_hold_addr", mem_req_addr, a);
          chk("mem_hold_data", mem_req_data, d);
        end
        mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0;
        accepted = 1;
        k = 0;
        while (hold_resp && k < 200) begin @(negedge clk); k++; end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        mem_resp_valid = 1;
        mem_resp_data = w ? {$urandom, $urandom} : (amem.exists(a) ? amem[a] : init_val(a));
        if (w) amem[a] = d;
        @(negedge clk);
        mem_resp_valid = 0;
        mem_resp_data = '0;
      end
    end
  end

  always @(posedge clk) if (mem_resp_valid) rv_cyc = cyc;

  // Response monitor: every completion pulse pops one expected response.
  initial begin
    rop_t r;
    forever begin
      @(negedge clk);
      cyc++;
      if (ca_respcyc) begin
        chk("resp_expected", 64'(exp_resp_q.size() > 0), 64'd1);
        if (exp_resp_q.size() > 0) begin
          r = exp_resp_q.pop_front();
          chk("resp_data", ca_resp_data, r.d);
          if (r.miss) chk("miss_latency", 64'(cyc - rv_cyc), 64'd1);
        end
      end else if (ca_resp_data !== '0) chk("idle_resp_data", ca_resp_data, 64'd0);
    end
  end

  task automatic issue(input cache_cmd_t cmd, input logic [63:0] a, input logic [63:0] d);
    logic [63:0] wa, exp, victim;
    bit hit, vf, seen;
    int n;
    wa = a & ~64'h7;
    hit = cached.exists(wa);
    exp = '0;
    if (cmd == CMD_READ && hit) exp = cached[wa];
    else if (cmd == CMD_READ) begin
      exp = refmem.exists(wa) ? refmem[wa] : init_val(wa);
      exp_mem_q.push_back('{1'b0, wa, 64'd0});
      vf = 0;
      victim = '0;
      foreach (cached[k]) if (idx_of(k) == idx_of(wa)) begin victim = k; vf = 1; end
      if (vf) cached.delete(victim);
      cached[wa] = exp;
    end else if (cmd == CMD_WRITE) begin
      exp_mem_q.push_back('{1'b1, wa, d});
      refmem[wa] = d;
      if (hit) cached[wa] = d;
    end else if (hit) cached.delete(wa);
    exp_resp_q.push_back('{exp, !(cmd == CMD_FLUSH || (cmd == CMD_READ && hit))});
    @(posedge clk);
    #1;
    ca_req_cmd = cmd; ca_req_addr = a; ca_req_data = d;
    n = 0; seen = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      if (ca_respcyc) seen = 1; else n++;
    end
    chk("resp_seen", 64'(seen), 64'd1);
    if (cmd == CMD_FLUSH || (cmd == CMD_READ && hit)) chk("fast_latency", 64'(n), 64'd2);
  endtask

  task automatic idle(input int k);
    @(posedge clk);
    #1 ca_req_cmd = CMD_IDLE;
    repeat (k) @(posedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_respcyc"}, 64'(ca_respcyc), 64'd0);
    chk({tag, "_resp_data"}, ca_resp_data, 64'd0);
    chk({tag, "_mem_valid"}, 64'(mem_req_valid), 64'd0);
    chk({tag, "_mem_write"}, 64'(mem_req_write), 64'd0);
    chk({tag, "_mem_addr"}, mem_req_addr, 64'd0);
    chk({tag, "_mem_data"}, mem_req_data, 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    int n, r;
    amem[64'h1000] = 64'h1122334455667788;
    refmem[64'h1000] = 64'h1122334455667788;
    repeat (3) @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 reset = 1;
    repeat (2) @(posedge clk);
    issue(CMD_READ, 64'h1000, 0);
    issue(CMD_READ, 64'h1000, 0);
    issue(CMD_WRITE, 64'h1000, 64'hDEADBEEF);
    issue(CMD_READ, 64'h1005, 0);
    idle(2);
    issue(CMD_FLUSH, 64'h3000, 0);
    issue(CMD_READ, 64'h1000, 0);
    issue(CMD_FLUSH, 64'h1000, 0);
    issue(CMD_READ, 64'h1000, 0);
    issue(CMD_WRITE, 64'h2000, 64'hCAFEF00D12345678);
    issue(CMD_READ, 64'h2000, 0);
    force_stall = 5;
    issue(CMD_READ, 64'h1200, 0);
    force_stall = -1;
    issue(CMD_READ, 64'h1000, 0);
    issue(CMD_READ, 64'h1200, 0);
    issue(CMD_WRITE, 64'h1208, 64'h0F0F);
    issue(CMD_READ, 64'h1208, 0);
    idle(1);
    // Reset while the memory read is outstanding; its late response must be dropped.
    hold_resp = 1;
    accepted = 0;
    exp_mem_q.push_back('{1'b0, 64'h5000, 64'd0});
    @(posedge clk);
    #1 ca_req_cmd = CMD_READ; ca_req_addr = 64'h5000;
    n = 0;
    while (!accepted && n < 100) begin @(negedge clk); n++; end
    chk("mwait_reached", 64'(accepted), 64'd1);
    @(posedge clk);
    #1 reset = 0; ca_req_cmd = CMD_IDLE;
    @(negedge clk);
    check_zero("mwait_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1;
    cached.delete();
    hold_resp = 0;
    repeat (8) @(posedge clk);
    issue(CMD_READ, 64'h5000, 0);
    issue(CMD_READ, 64'h1200, 0);
    idle(0);
    for (int i = 0; i < 300; i++) begin
      a = (64'($urandom_range(0, 2)) << 9) | (64'($urandom_range(0, 3)) << 3) | 64'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a[63] = 1'b1;
      r = int'($urandom_range(0, 9));
      issue(r < 5 ? CMD_READ : (r < 8 ? CMD_WRITE : CMD_FLUSH), a, {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 2)));
    end
    idle(0);
    repeat (12) @(posedge clk);
    chk("resp_queue_drained", 64'(exp_resp_q.size()), 64'd0);
    chk("mem_queue_drained", 64'(exp_mem_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
